// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline definitions: forwarding mux selects and hazard FSM states.
// The EX-stage operand muxes decode the same fwd_sel_e values.
package hazard_forward_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b01
    } fwd_sel_e;

    typedef enum logic {
        StIdle = 1'b0,
        StLong = 1'b1
    } long_state_e;

    localparam int unsigned CntW = 4;

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one EX source operand; MEM result wins over WB.
module fwd_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0] ex_src_i,
    input  logic [AW-1:0] mem_dest_i,
    input  logic          mem_regwrite_i,
    input  logic [AW-1:0] wb_dest_i,
    input  logic          wb_regwrite_i,
    output logic [1:0]    fwd_o
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite_i && (mem_dest_i != '0) && (mem_dest_i == ex_src_i)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite_i && (wb_dest_i != '0) && (wb_dest_i == ex_src_i)) begin
            sel = FWD_WB;
        end
    end

    assign fwd_o = sel;

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding plus load-use and long-latency-op stall generation.
// A single outstanding long op is tracked by a down-counter and its latched destination.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned AW       = 5,
    parameter int unsigned NSRC     = 2,
    parameter int unsigned LONG_LAT = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [NSRC*AW-1:0]   ID_Src,
    input  logic [NSRC*AW-1:0]   EX_Src,
    input  logic [AW-1:0]        EX_Dest,
    input  logic [AW-1:0]        MEM_Dest,
    input  logic [AW-1:0]        WB_Dest,
    input  logic                 EX_RegWrite,
    input  logic                 MEM_RegWrite,
    input  logic                 WB_RegWrite,
    input  logic                 EX_MemRead,
    input  logic                 Long_Issue,
    input  logic [AW-1:0]        Long_Dest,
    output logic [NSRC*2-1:0]    Forward,
    output logic                 Stall,
    output logic                 Bubble,
    output logic                 Long_Busy
);

    localparam logic [CntW-1:0] CntLoad = CntW'(LONG_LAT - 1);

    long_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   dest_q, dest_d;

    logic load_use;
    logic long_hazard;

    for (genvar i = 0; i < NSRC; i++) begin : g_fwd
        fwd_select #(
            .AW(AW)
        ) u_fwd_select (
            .ex_src_i      (EX_Src[i*AW +: AW]),
            .mem_dest_i    (MEM_Dest),
            .mem_regwrite_i(MEM_RegWrite),
            .wb_dest_i     (WB_Dest),
            .wb_regwrite_i (WB_RegWrite),
            .fwd_o         (Forward[i*2 +: 2])
        );
    end

    always_comb begin
        load_use    = 1'b0;
        long_hazard = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (EX_MemRead && EX_RegWrite && (EX_Dest != '0) &&
                (ID_Src[i*AW +: AW] == EX_Dest)) begin
                load_use = 1'b1;
            end
            // dest_q is never zero while in StLong, so address 0 cannot match here.
            if ((state_q == StLong) && (ID_Src[i*AW +: AW] == dest_q)) begin
                long_hazard = 1'b1;
            end
        end
        if ((state_q == StLong) && Long_Issue) begin
            long_hazard = 1'b1;
        end
    end

    assign Stall     = load_use | long_hazard;
    assign Bubble    = Stall;
    assign Long_Busy = (state_q == StLong);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        unique case (state_q)
            StIdle: begin
                if (Long_Issue && (Long_Dest != '0)) begin
                    state_d = StLong;
                    cnt_d   = CntLoad;
                    dest_d  = Long_Dest;
                end
            end
            StLong: begin
                // Issues arriving here are stalled in ID, so they never reload.
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    dest_d  = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                dest_d  = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: stimulus pushes expected outputs from a reference model; a monitor checks.
module tb_hazard_forward_unit;

    localparam int unsigned AW       = 5;
    localparam int unsigned NSRC     = 2;
    localparam int unsigned LONG_LAT = 4;

    typedef struct {
        logic [NSRC*AW-1:0] id_src;
        logic [NSRC*AW-1:0] ex_src;
        logic [AW-1:0]      ex_dest;
        logic [AW-1:0]      mem_dest;
        logic [AW-1:0]      wb_dest;
        logic [AW-1:0]      long_dest;
        logic               ex_rw;
        logic               mem_rw;
        logic               wb_rw;
        logic               ex_mr;
        logic               long_issue;
        logic               rst_n;
    } stim_t;

    typedef struct {
        logic [NSRC*2-1:0] fwd;
        logic              stall;
        logic              busy;
        string             tag;
    } exp_t;

    logic               Clk = 1'b0;
    logic               Rst_n;
    logic [NSRC*AW-1:0] ID_Src, EX_Src;
    logic [AW-1:0]      EX_Dest, MEM_Dest, WB_Dest, Long_Dest;
    logic               EX_RegWrite, MEM_RegWrite, WB_RegWrite, EX_MemRead, Long_Issue;
    logic [NSRC*2-1:0]  Forward;
    logic               Stall, Bubble, Long_Busy;

    hazard_forward_unit #(
        .AW      (AW),
        .NSRC    (NSRC),
        .LONG_LAT(LONG_LAT)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .ID_Src      (ID_Src),
        .EX_Src      (EX_Src),
        .EX_Dest     (EX_Dest),
        .MEM_Dest    (MEM_Dest),
        .WB_Dest     (WB_Dest),
        .EX_RegWrite (EX_RegWrite),
        .MEM_RegWrite(MEM_RegWrite),
        .WB_RegWrite (WB_RegWrite),
        .EX_MemRead  (EX_MemRead),
        .Long_Issue  (Long_Issue),
        .Long_Dest   (Long_Dest),
        .Forward     (Forward),
        .Stall       (Stall),
        .Bubble      (Bubble),
        .Long_Busy   (Long_Busy)
    );

    always #5 Clk = ~Clk;

    exp_t  exp_q[$];
    stim_t cur;
    int    remaining = 0;
    logic [AW-1:0] long_reg = '0;
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s.id_src = '0; s.ex_src = '0; s.ex_dest = '0; s.mem_dest = '0; s.wb_dest = '0;
        s.long_dest = '0; s.ex_rw = 0; s.mem_rw = 0; s.wb_rw = 0; s.ex_mr = 0;
        s.long_issue = 0; s.rst_n = 1;
        return s;
    endfunction

    function automatic logic [AW-1:0] src_of(input logic [NSRC*AW-1:0] v, input int i);
        return v[i*AW +: AW];
    endfunction

    // Reference: outputs derived directly from the rules with the current inputs and busy window.
    function automatic exp_t predict(input stim_t s, input string tag);
        exp_t e;
        logic lu, lh;
        e.fwd = '0;
        lu = 0; lh = 0;
        for (int i = 0; i < NSRC; i++) begin
            logic [AW-1:0] es, is;
            es = src_of(s.ex_src, i);
            is = src_of(s.id_src, i);
            if (s.mem_rw && s.mem_dest != 0 && s.mem_dest == es) e.fwd[i*2 +: 2] = 2'b10;
            else if (s.wb_rw && s.wb_dest != 0 && s.wb_dest == es) e.fwd[i*2 +: 2] = 2'b01;
            if (s.ex_mr && s.ex_rw && s.ex_dest != 0 && s.ex_dest == is) lu = 1;
            if (remaining > 0 && is != 0 && is == long_reg) lh = 1;
        end
        if (remaining > 0 && s.long_issue) lh = 1;
        e.stall = lu | lh;
        e.busy  = (remaining > 0);
        e.tag   = tag;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        ID_Src = s.id_src; EX_Src = s.ex_src; EX_Dest = s.ex_dest; MEM_Dest = s.mem_dest;
        WB_Dest = s.wb_dest; Long_Dest = s.long_dest; EX_RegWrite = s.ex_rw;
        MEM_RegWrite = s.mem_rw; WB_RegWrite = s.wb_rw; EX_MemRead = s.ex_mr;
        Long_Issue = s.long_issue; Rst_n = s.rst_n;
    endtask

    task automatic step(input stim_t s, input string tag);
        @(posedge Clk);
        if (cur.rst_n) begin
            if (remaining > 0) remaining--;
            else if (cur.long_issue && cur.long_dest != 0) begin
                remaining = LONG_LAT - 1;
                long_reg  = cur.long_dest;
            end
        end
        #1;
        cur = s;
        if (!s.rst_n) remaining = 0;
        drive(s);
        exp_q.push_back(predict(s, tag));
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".forward"}, 32'(Forward), 32'(e.fwd));
            chk({e.tag, ".stall"}, 32'(Stall), 32'(e.stall));
            chk({e.tag, ".bubble"}, 32'(Bubble), 32'(e.stall));
            chk({e.tag, ".busy"}, 32'(Long_Busy), 32'(e.busy));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        cur = idle_stim();
        cur.rst_n = 0;
        drive(cur);
        s = idle_stim(); s.rst_n = 0;
        step(s, "reset");
        step(s, "reset");

        // MEM/WB both write 5: MEM wins, then WB alone.
        s = idle_stim();
        s.mem_dest = 5; s.mem_rw = 1; s.wb_dest = 5; s.wb_rw = 1; s.ex_src = {5'd0, 5'd5};
        step(s, "fwd_mem");
        s.mem_rw = 0;
        step(s, "fwd_wb");

        // Load-use: one stall cycle, then forward from MEM.
        s = idle_stim();
        s.ex_dest = 8; s.ex_rw = 1; s.ex_mr = 1; s.id_src = {5'd8, 5'd1};
        step(s, "load_use");
        s = idle_stim();
        s.mem_dest = 8; s.mem_rw = 1; s.ex_src = {5'd8, 5'd1};
        step(s, "load_fwd");

        // Long op to 12, consumer in ID, second issue while busy.
        s = idle_stim(); s.long_issue = 1; s.long_dest = 12;
        step(s, "long_issue");
        s = idle_stim(); s.id_src = {5'd0, 5'd12};
        step(s, "long_dep");
        s.long_issue = 1; s.long_dest = 7;
        step(s, "long_struct");
        step(s, "long_struct");
        step(s, "long_accept");
        s = idle_stim();
        for (int k = 0; k < 5; k++) step(s, "long_drain");

        // Zero addresses never forward or stall.
        s = idle_stim();
        s.ex_rw = 1; s.mem_rw = 1; s.wb_rw = 1; s.ex_mr = 1;
        step(s, "zero_regs");

        // Reset in the second LONG cycle.
        s = idle_stim(); s.long_issue = 1; s.long_dest = 12;
        step(s, "rst_issue");
        s = idle_stim(); s.id_src = {5'd0, 5'd12};
        step(s, "rst_long1");
        s.rst_n = 0;
        step(s, "rst_mid");
        s.rst_n = 1;
        step(s, "rst_release");
        step(s, "rst_after");

        for (int n = 0; n < 3000; n++) begin
            s.id_src     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            s.ex_src     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            s.ex_dest    = 5'($urandom_range(0, 3));
            s.mem_dest   = 5'($urandom_range(0, 3));
            s.wb_dest    = 5'($urandom_range(0, 3));
            s.long_dest  = 5'($urandom_range(0, 3));
            s.ex_rw      = 1'($urandom);
            s.mem_rw     = 1'($urandom);
            s.wb_rw      = 1'($urandom);
            s.ex_mr      = 1'($urandom);
            s.long_issue = ($urandom_range(0, 3) == 0);
            s.rst_n      = ($urandom_range(0, 39) != 0);
            step(s, "rand");
        end

        @(negedge Clk);
        @(negedge Clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
